motor_ramp_pwm: RTL and testbench
=================================

# motor_ramp_pwm

Multi-channel, slew-rate-limited PWM motor driver. It is the parametrised successor to the fixed two-channel speed-table driver. Each channel accepts a signed speed target (direction + magnitude) and ramps its duty toward it once per PWM period. Direction reversals are forced through zero plus a dead-time, and an emergency stop overrides everything. It sits between the car's mode/steering logic and the H-bridge pins: `pwm` drives the enable pins and `dir` drives the IN pins.

## Interface
- `N_CH`, default 2: number of motor channels, ≥1.
- `DUTY_W`, default 10: magnitude width in bits.
- `PERIOD`, default 4000: PWM period in clk cycles, ≥2 (4000 = 25 kHz at 100 MHz).
- `RAMP_STEP`, default 32: maximum magnitude change per period, 1..2^DUTY_W−1.
- `DEAD_PER`, default 2: periods held at zero before a direction flip, ≥1.
- `clk` input 1: system clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `tgt_valid` input 1: load strobe for all channel targets. Always accepted; no ready signal.
- `tgt_dir` input N_CH: requested direction per channel (1 = reverse).
- `tgt_mag` input N_CH*DUTY_W: requested magnitude per channel. Channel i occupies bits [i*DUTY_W +: DUTY_W].
- `estop` input 1: synchronous emergency stop, level-sensitive.
- `pwm` output N_CH: PWM per channel.
- `dir` output N_CH: applied direction per channel.
- `at_target` output N_CH: channel has settled at its target.
- `period_tick` output 1: one-cycle pulse on the last cycle of each period.

## Operation
**Reset**
- All outputs are 0.
- cnt, and every channel's tgt/cur magnitude, cur direction and cmp, are 0.
- All channel states are RUN.

**Period counter (shared)**
- cnt counts 0..PERIOD−1 and wraps.
- tick = (cnt == PERIOD−1).

**Target latch**
- On tgt_valid, each channel's tgt_dir/tgt_mag registers load.
- A target that arrives mid-period is first acted on at the next tick.

**Per-channel FSM.** States RUN, BRAKE, DEAD. All transitions occur only on tick.
- RUN, tgt_mag == 0: cur_mag decreases by min(RAMP_STEP, cur_mag). Direction is never changed.
- RUN, tgt_dir == cur_dir: cur_mag moves toward tgt_mag by at most RAMP_STEP, with no overshoot.
- RUN, tgt_dir ≠ cur_dir and tgt_mag ≠ 0:
  - If cur_mag > 0, go to BRAKE.
  - If cur_mag == 0, go to DEAD with dead_cnt = DEAD_PER−1.
- BRAKE: cur_mag decreases by min(RAMP_STEP, cur_mag). Once it reaches 0, go to DEAD with dead_cnt = DEAD_PER−1.
- BRAKE, target reverts to cur_dir: return to RUN on that tick and ramp normally from there.
- DEAD: cur_mag is held at 0.
  - If dead_cnt == 0: cur_dir ← tgt_dir and go to RUN.
  - Otherwise dead_cnt decrements.
  - A target that reverts to the old direction is still honoured by the flip.

**Compare value**
- On each tick, cmp ← (new cur_mag × PERIOD) >> DUTY_W. The multiply is (DUTY_W + clog2(PERIOD)) bits wide and is truncated.
- cmp changes only at the period boundary, so output pulses are never glitched mid-period.
- The maximum duty is (2^DUTY_W−1)/2^DUTY_W. 100 % duty is not reachable, by design.

**Outputs**
- pwm[i] ← (cnt < cmp[i]) every cycle (registered).
- dir[i] = cur_dir[i] (registered).
- at_target[i] = (state == RUN) && (cur_mag == tgt_mag) && (tgt_mag == 0 || cur_dir == tgt_dir).

**estop**
- While high, every channel is forced to cur_mag = 0, cmp = 0, tgt_mag = 0 and state RUN, on the next clk edge (not tick-aligned). tgt_valid is ignored.
- dir is held.
- After estop falls, channels stay at 0 until a new tgt_valid.

## Timing
- pwm has a 1-cycle latency from cnt.
- The first pwm high after a target change appears in the cycle after the tick, i.e. cycle 0 of the next period is driven high.
- Ramp time from 0 to M is ceil(M / RAMP_STEP) periods.
- Reversal time is ceil(cur_mag / RAMP_STEP) + DEAD_PER periods, then the ramp-up.
- estop to pwm low is at most 2 clk cycles.
- Reset asserted mid-operation forces all outputs to 0 immediately (asynchronous). Release is synchronised by the usual reset synchroniser upstream.
- tgt_valid coincident with tick: the new target is used from the next tick onward. The current tick uses the old target.

## Structure
- Package `motor_pkg` holds:
  - the `ch_state_t` enum (RUN, BRAKE, DEAD);
  - the default parameter constants;
  - the cmp-width function.
- Sub-module `motor_ramp_ch` implements one channel: FSM, cur_mag, cmp, pwm compare and at_target. It is instantiated N_CH times by generate.
- The top level owns cnt, tick, period_tick and the estop fan-out.

## Test plan
All scenarios use N_CH=2, DUTY_W=8, PERIOD=100, RAMP_STEP=32, DEAD_PER=2.

1. **Reset:** drive rst_n=0 mid-period → pwm, dir, at_target and period_tick read 0 immediately. period_tick first pulses 100 cycles after release.
2. **Ramp-up:** ch0 tgt_mag=128, dir=0 → cur_mag 32, 64, 96, 128 on successive ticks. at_target rises after the 4th tick. pwm is high 50 of every 100 cycles thereafter.
3. **Reversal:** ch0 at mag 64, dir 0; load dir=1, mag=64 → mag 32 then 0 (BRAKE), then 2 periods at 0, dir flips, then mag 32 then 64. at_target is low throughout and high after the last step.
4. **Saturation and truncation:** tgt_mag=255 → settles at cmp=99, with pwm high 99 of 100 cycles. tgt_mag=20 from 0 → reaches 20 in a single tick with no overshoot.
5. **estop:** assert estop with ch1 at mag 200 → pwm[1] low within 2 cycles, dir[1] unchanged. Deassert with no new tgt_valid → pwm stays 0.
6. **Independence and coincidence:** ch0 ramps up while ch1 reverses, with tgt_valid pulsed on a tick cycle → each channel follows its own sequence, and the new target is applied one period later.

Source files
------------

// File: rtl/motor_ramp_pwm_pkg.sv
// Shared types, default parameters and width helper for the motor_ramp_pwm slice.
package motor_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    BRAKE = 2'd1,
    DEAD  = 2'd2
  } ch_state_t;

  localparam int unsigned DEF_N_CH      = 2;
  localparam int unsigned DEF_DUTY_W    = 10;
  localparam int unsigned DEF_PERIOD    = 4000;
  localparam int unsigned DEF_RAMP_STEP = 32;
  localparam int unsigned DEF_DEAD_PER  = 2;

  // Bits needed to hold 0..n-1 (cnt, cmp and dead_cnt), never narrower than 1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/motor_ramp_pwm_if.sv
// Target-load bus from the mode/steering logic into the motor driver.
interface motor_ramp_pwm_if #(
  parameter int unsigned N_CH   = 2,
  parameter int unsigned DUTY_W = 10
);
  logic                     tgt_valid;
  logic [N_CH-1:0]          tgt_dir;
  logic [N_CH*DUTY_W-1:0]   tgt_mag;

  modport master (output tgt_valid, output tgt_dir, output tgt_mag);
  modport slave  (input  tgt_valid, input  tgt_dir, input  tgt_mag);
endinterface

// File: rtl/motor_ramp_pwm_ch.sv
// One motor channel: target latch, RUN/BRAKE/DEAD ramp FSM, compare value and PWM.
module motor_ramp_ch
  import motor_pkg::*;
#(
  parameter int unsigned DUTY_W    = DEF_DUTY_W,
  parameter int unsigned PERIOD    = DEF_PERIOD,
  parameter int unsigned RAMP_STEP = DEF_RAMP_STEP,
  parameter int unsigned DEAD_PER  = DEF_DEAD_PER
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         tick,
  input  logic [cnt_width(PERIOD)-1:0] cnt,
  input  logic                         estop,
  input  logic                         ld,
  input  logic                         ld_dir,
  input  logic [DUTY_W-1:0]            ld_mag,
  output logic                         pwm,
  output logic                         dir,
  output logic                         at_target
);

  localparam int unsigned CW  = cnt_width(PERIOD);
  localparam int unsigned DCW = cnt_width(DEAD_PER);
  localparam int unsigned PW  = DUTY_W + CW;
  localparam logic [DUTY_W-1:0] STEP      = DUTY_W'(RAMP_STEP);
  localparam logic [PW-1:0]     PERIOD_W  = PW'(PERIOD);
  localparam logic [DCW-1:0]    DEAD_INIT = DCW'(DEAD_PER - 1);

  ch_state_t          state, nxt_state;
  logic               tgt_dir_q, cur_dir, nxt_dir;
  logic [DUTY_W-1:0]  tgt_mag_q, cur_mag, nxt_mag, dec_mag, toward_mag;
  logic [DCW-1:0]     dead_cnt, nxt_dead;
  logic [CW-1:0]      cmp;
  logic [PW-1:0]      prod;

  always_comb begin
    dec_mag = (cur_mag > STEP) ? cur_mag - STEP : '0;
    if (tgt_mag_q >= cur_mag)
      toward_mag = ((tgt_mag_q - cur_mag) > STEP) ? cur_mag + STEP : tgt_mag_q;
    else
      toward_mag = ((cur_mag - tgt_mag_q) > STEP) ? cur_mag - STEP : tgt_mag_q;

    nxt_state = state;
    nxt_dir   = cur_dir;
    nxt_mag   = cur_mag;
    nxt_dead  = dead_cnt;

    case (state)
      DEAD: begin
        nxt_mag = '0;
        if (dead_cnt == '0) begin
          nxt_dir   = tgt_dir_q;
          nxt_state = RUN;
        end else begin
          nxt_dead = dead_cnt - 1'b1;
        end
      end
      default: begin
        // RUN and BRAKE share the decision tree: a BRAKE whose target reverts
        // (or drops to zero) simply resumes RUN behaviour on this tick, and
        // the first braking step is taken on the tick that detects reversal.
        if (tgt_mag_q == '0) begin
          nxt_mag   = dec_mag;
          nxt_state = RUN;
        end else if (tgt_dir_q == cur_dir) begin
          nxt_mag   = toward_mag;
          nxt_state = RUN;
        end else if (cur_mag == '0) begin
          nxt_state = DEAD;
          nxt_dead  = DEAD_INIT;
        end else begin
          nxt_mag = dec_mag;
          if (dec_mag == '0) begin
            nxt_state = DEAD;
            nxt_dead  = DEAD_INIT;
          end else begin
            nxt_state = BRAKE;
          end
        end
      end
    endcase

    prod = PW'(nxt_mag) * PERIOD_W;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      tgt_dir_q <= 1'b0;
      tgt_mag_q <= '0;
      cur_dir   <= 1'b0;
      cur_mag   <= '0;
      dead_cnt  <= '0;
      cmp       <= '0;
      pwm       <= 1'b0;
      dir       <= 1'b0;
      at_target <= 1'b0;
    end else begin
      pwm       <= (cnt < cmp);
      dir       <= cur_dir;
      at_target <= (state == RUN) && (cur_mag == tgt_mag_q) &&
                   ((tgt_mag_q == '0) || (cur_dir == tgt_dir_q));
      if (estop) begin
        state     <= RUN;
        cur_mag   <= '0;
        cmp       <= '0;
        tgt_mag_q <= '0;
      end else begin
        if (ld) begin
          tgt_dir_q <= ld_dir;
          tgt_mag_q <= ld_mag;
        end
        if (tick) begin
          state    <= nxt_state;
          cur_dir  <= nxt_dir;
          cur_mag  <= nxt_mag;
          dead_cnt <= nxt_dead;
          cmp      <= CW'(prod >> DUTY_W);
        end
      end
    end
  end

endmodule

// File: rtl/motor_ramp_pwm.sv
// Multi-channel slew-limited PWM motor driver: shared period counter plus N_CH ramp channels.
module motor_ramp_pwm
  import motor_pkg::*;
#(
  parameter int unsigned N_CH      = DEF_N_CH,
  parameter int unsigned DUTY_W    = DEF_DUTY_W,
  parameter int unsigned PERIOD    = DEF_PERIOD,
  parameter int unsigned RAMP_STEP = DEF_RAMP_STEP,
  parameter int unsigned DEAD_PER  = DEF_DEAD_PER
) (
  input  logic                 clk,
  input  logic                 rst_n,
  motor_ramp_pwm_if.slave      tgt,
  input  logic                 estop,
  output logic [N_CH-1:0]      pwm,
  output logic [N_CH-1:0]      dir,
  output logic [N_CH-1:0]      at_target,
  output logic                 period_tick
);

  localparam int unsigned CW = cnt_width(PERIOD);
  localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt;
  logic          tick;

  assign tick        = (cnt == CNT_LAST);
  assign period_tick = tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (tick)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    motor_ramp_ch #(
      .DUTY_W    (DUTY_W),
      .PERIOD    (PERIOD),
      .RAMP_STEP (RAMP_STEP),
      .DEAD_PER  (DEAD_PER)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick      (tick),
      .cnt       (cnt),
      .estop     (estop),
      .ld        (tgt.tgt_valid),
      .ld_dir    (tgt.tgt_dir[i]),
      .ld_mag    (tgt.tgt_mag[i*DUTY_W +: DUTY_W]),
      .pwm       (pwm[i]),
      .dir       (dir[i]),
      .at_target (at_target[i])
    );
  end

endmodule

// File: tb/tb_motor_ramp_pwm.sv
// Directed bench for motor_ramp_pwm: per-period duty counts against hand-computed compare values.
module tb_motor_ramp_pwm;

  localparam int unsigned N_CH      = 2;
  localparam int unsigned DUTY_W    = 8;
  localparam int unsigned PERIOD    = 100;
  localparam int unsigned RAMP_STEP = 32;
  localparam int unsigned DEAD_PER  = 2;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       estop = 1'b0;
  logic [1:0] pwm, dir, at_target;
  logic       period_tick;

  int errors = 0;
  int checks = 0;

  motor_ramp_pwm_if #(.N_CH(N_CH), .DUTY_W(DUTY_W)) tgt_if ();

  motor_ramp_pwm #(
    .N_CH      (N_CH),
    .DUTY_W    (DUTY_W),
    .PERIOD    (PERIOD),
    .RAMP_STEP (RAMP_STEP),
    .DEAD_PER  (DEAD_PER)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tgt         (tgt_if),
    .estop       (estop),
    .pwm         (pwm),
    .dir         (dir),
    .at_target   (at_target),
    .period_tick (period_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int all_outs();
    return int'({pwm, dir, at_target, period_tick});
  endfunction

  task automatic load(input logic d0, input int m0, input logic d1, input int m1);
    @(negedge clk);
    tgt_if.tgt_valid = 1'b1;
    tgt_if.tgt_dir   = {d1, d0};
    tgt_if.tgt_mag   = {8'(m1), 8'(m0)};
    @(negedge clk);
    tgt_if.tgt_valid = 1'b0;
  endtask

  // Leaves the caller at the negedge inside the tick cycle (cnt == PERIOD-1).
  task automatic tick_sync();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!period_tick && k < 300);
    check("tick_seen", int'(period_tick), 1);
  endtask

  // From a tick-cycle negedge, counts pwm-high cycles over the next period; the
  // count equals the cmp loaded at that tick and the call ends on the next tick cycle.
  task automatic duty(output int h0, output int h1);
    h0 = 0;
    h1 = 0;
    for (int k = 0; k < int'(PERIOD); k++) begin
      @(negedge clk);
      tgt_if.tgt_valid = 1'b0;
      h0 += int'(pwm[0]);
      h1 += int'(pwm[1]);
    end
  endtask

  // cnt starts at 0 in the release cycle, so the first tick is the 99th negedge after it.
  task automatic release_and_time();
    int k;
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    while (!period_tick && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("tick_after_rst", k, int'(PERIOD) - 1);
  endtask

  initial begin
    int h0, h1;
    int r2_0[5] = '{12, 25, 37, 50, 50};
    int r2_a[5] = '{2, 2, 2, 3, 3};
    int r3_0[6] = '{12, 0, 0, 0, 12, 25};
    int r3_d[6] = '{0, 0, 0, 1, 1, 1};
    int r3_a[6] = '{2, 2, 2, 2, 2, 3};
    int r6_0[7] = '{0, 12, 25, 37, 37, 37, 37};
    int r6_1[7] = '{25, 12, 0, 0, 0, 12, 25};
    int r6_d[7] = '{1, 1, 1, 1, 3, 3, 3};
    int r6_a[7] = '{0, 0, 0, 1, 1, 1, 3};

    tgt_if.tgt_valid = 1'b0;
    tgt_if.tgt_dir   = '0;
    tgt_if.tgt_mag   = '0;

    // Reset state and first tick timing.
    repeat (3) @(negedge clk);
    check("rst_outputs", all_outs(), 0);
    release_and_time();

    // Ramp-up on ch0 to 128; ch1 jumps 0->20 in a single step (cmp 7).
    load(1'b0, 128, 1'b0, 20);
    tick_sync();
    for (int i = 0; i < 5; i++) begin
      duty(h0, h1);
      check($sformatf("ramp_p%0d_ch0", i), h0, r2_0[i]);
      check($sformatf("ramp_p%0d_ch1", i), h1, 7);
      check($sformatf("ramp_p%0d_at", i), int'(at_target), r2_a[i]);
    end
    check("ramp_dir", int'(dir), 0);

    // Down-ramp ch0 to 64, then reverse it.
    load(1'b0, 64, 1'b0, 20);
    tick_sync();
    duty(h0, h1);
    check("down_p0_ch0", h0, 37);
    duty(h0, h1);
    check("down_p1_ch0", h0, 25);
    load(1'b1, 64, 1'b0, 20);
    tick_sync();
    for (int i = 0; i < 6; i++) begin
      duty(h0, h1);
      check($sformatf("rev_p%0d_ch0", i), h0, r3_0[i]);
      check($sformatf("rev_p%0d_dir", i), int'(dir), r3_d[i]);
      check($sformatf("rev_p%0d_at", i), int'(at_target), r3_a[i]);
    end

    // Saturation: ch1 20 -> 255 ends at cmp 99.
    load(1'b1, 64, 1'b0, 255);
    tick_sync();
    for (int i = 0; i < 8; i++) begin
      duty(h0, h1);
      if (i == 6) begin
        check("sat_p6_ch1", h1, 95);
        check("sat_p6_at", int'(at_target), 1);
      end
    end
    check("sat_final_ch1", h1, 99);
    check("sat_final_ch0", h0, 25);
    check("sat_final_at", int'(at_target), 3);

    // estop with ch1 at 200.
    load(1'b1, 64, 1'b0, 200);
    tick_sync();
    duty(h0, h1);
    check("pre_es_p0_ch1", h1, 87);
    duty(h0, h1);
    check("pre_es_p1_ch1", h1, 78);
    repeat (10) @(negedge clk);
    check("pre_es_pwm", int'(pwm), 3);
    estop = 1'b1;
    repeat (2) @(negedge clk);
    check("es_pwm_2cyc", int'(pwm), 0);
    check("es_dir_held", int'(dir), 1);
    tgt_if.tgt_valid = 1'b1;
    tgt_if.tgt_dir   = 2'b00;
    tgt_if.tgt_mag   = {8'd100, 8'd100};
    @(negedge clk);
    tgt_if.tgt_valid = 1'b0;
    h1 = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      h1 += int'(pwm != 2'b00);
    end
    check("es_hold_pwm", h1, 0);
    estop = 1'b0;
    tick_sync();
    duty(h0, h1);
    duty(h0, h1);
    check("post_es_pwm", h0 + h1, 0);
    check("post_es_at", int'(at_target), 3);
    check("post_es_dir", int'(dir), 1);

    // Independence: ch0 ramps while ch1 reverses; new targets land on a tick cycle.
    load(1'b1, 0, 1'b0, 64);
    tick_sync();
    duty(h0, h1);
    check("ind_pre0_ch1", h1, 12);
    duty(h0, h1);
    check("ind_pre1_ch1", h1, 25);
    tgt_if.tgt_valid = 1'b1;
    tgt_if.tgt_dir   = 2'b11;
    tgt_if.tgt_mag   = {8'd64, 8'd96};
    for (int i = 0; i < 7; i++) begin
      duty(h0, h1);
      check($sformatf("ind_p%0d_ch0", i), h0, r6_0[i]);
      check($sformatf("ind_p%0d_ch1", i), h1, r6_1[i]);
      check($sformatf("ind_p%0d_dir", i), int'(dir), r6_d[i]);
      check($sformatf("ind_p%0d_at", i), int'(at_target), r6_a[i]);
    end

    // Asynchronous reset mid-period.
    repeat (5) @(negedge clk);
    check("pre_rst_pwm", int'(pwm), 3);
    #2 rst_n = 1'b0;
    #1 check("async_rst_outputs", all_outs(), 0);
    release_and_time();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
